sys_mem_responder: RTL and testbench

- Byte-wide main-memory responder for the system bus driven by the L1 cache controller, which is the initiator.
- Accepts a one-cycle request strobe carrying address and direction, then inserts a fixed number of wait states.
- Then transfers exactly 4 bytes, one per cycle, to or from its internal byte array, and signals completion.
- Sits below the cache on the system side; it is the far end of every cache line fill (read) and write-through (write).

---
 rtl/sys_bus_pkg.sv | 27 ++
 rtl/sys_mem_array.sv | 27 ++
 rtl/sys_mem_responder.sv | 145 ++++++++++++++
 tb/tb_sys_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Purpose : shared types and constants for the system-bus memory responder.
// Latency : n/a (declarations only).
// Backpres: n/a; the system bus has no stall, the initiator waits on sysdone.
package sys_bus_pkg;

   // Responder FSM states: accept, wait states, 4 data beats, completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int   BEATS_PER_WORD = 4;
   localparam logic RW_READ        = 1'b1;
   localparam logic RW_WRITE       = 1'b0;

   // Beat index within a 4-byte aligned word.
   typedef logic [1:0] beat_t;

   // Byte offset of a beat; the 2-bit result wraps inside the aligned word,
   // so a burst never carries into the word address.
   function automatic beat_t beat_offset(input beat_t start, input beat_t beat);
      return beat_t'(start + beat);
   endfunction

endpackage

// File: rtl/sys_mem_array.sv
// Purpose : byte RAM, 2**ADDR_W x 8, one synchronous write port, one combinational read port.
// Latency : write lands on the clock edge; read data follows raddr in the same cycle.
// Backpres: none; every write strobe is taken.
// Ports   : clk; we/waddr/wdata write port; raddr -> rdata read port.
//           Contents are deliberately not reset.
module sys_mem_array #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sys_mem_responder.sv
// Purpose : main-memory responder on the system bus; one strobe moves one 4-byte word.
// Latency : beat k in cycle 1+WAIT_STATES+k after acceptance, sysdone in cycle 5+WAIT_STATES.
// Backpres: none; strobes outside IDLE are dropped, the initiator must wait for sysdone.
// Ports   : clk, rst_n (synchronous, active-low); request sysstrobe/sysrw/sysaddress;
//           write byte sysdata_in; read byte sysdata_out; status sysvalid/sysbusy/sysdone.
// Option  : `define SYS_MEM_CRIT_WORD_EN to start the burst at sysaddress[1:0] (critical
//           byte first, wrapping in the word); otherwise bursts start at offset 0.
module sys_mem_responder
   import sys_bus_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sysstrobe,
   input  logic              sysrw,
   input  logic [ADDR_W-1:0] sysaddress,
   input  logic [7:0]        sysdata_in,
   output logic [7:0]        sysdata_out,
   output logic              sysvalid,
   output logic              sysbusy,
   output logic              sysdone
);

   // Terminal value of the wait counter; unused when WAIT_STATES is 0.
   localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic              rw;
   beat_t             beat;
   logic [3:0]        wcnt;

   logic [ADDR_W-1:0] req_base;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        rd_byte;
   logic              mem_we;

`ifdef SYS_MEM_CRIT_WORD_EN
   // Keep the requested byte offset as the burst start.
   assign req_base = sysaddress;
`else
   assign req_base = {sysaddress[ADDR_W-1:2], 2'b00};
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^sysaddress[1:0];
`endif

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b, input beat_t k);
      return {b[ADDR_W-1:2], beat_offset(b[1:0], k)};
   endfunction

   // Write lands on the edge ending the current beat. Gating with rst_n keeps
   // a beat that is cut short by reset from writing its byte.
   assign wr_addr = beat_addr(base, beat);
   assign mem_we  = rst_n && (state == XFER) && (rw == RW_WRITE);

   // sysdata_out is registered, so the read port looks one beat ahead: it
   // presents the byte for the beat that the coming edge enters.
   always_comb begin
      rd_addr = beat_addr(base, 2'd0);
      if (state == IDLE) begin
         rd_addr = beat_addr(req_base, 2'd0);
      end else if (state == XFER) begin
         rd_addr = beat_addr(base, beat_t'(beat + 2'd1));
      end
   end

   sys_mem_array #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_addr),
      .wdata (sysdata_in),
      .raddr (rd_addr),
      .rdata (rd_byte)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         base        <= '0;
         rw          <= RW_WRITE;
         beat        <= '0;
         wcnt        <= '0;
         sysdata_out <= 8'h00;
         sysvalid    <= 1'b0;
         sysbusy     <= 1'b0;
         sysdone     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sysdata_out <= 8'h00;
               sysvalid    <= 1'b0;
               sysbusy     <= 1'b0;
               sysdone     <= 1'b0;
               if (sysstrobe) begin
                  base    <= req_base;
                  rw      <= sysrw;
                  beat    <= '0;
                  wcnt    <= '0;
                  sysbusy <= 1'b1;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                  end else begin
                     state       <= XFER;
                     sysvalid    <= 1'b1;
                     sysdata_out <= (sysrw == RW_READ) ? rd_byte : 8'h00;
                  end
               end
            end
            WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  state       <= XFER;
                  beat        <= '0;
                  sysvalid    <= 1'b1;
                  sysdata_out <= (rw == RW_READ) ? rd_byte : 8'h00;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            XFER: begin
               if (beat == beat_t'(BEATS_PER_WORD - 1)) begin
                  state       <= DONE;
                  sysvalid    <= 1'b0;
                  sysdata_out <= 8'h00;
                  sysdone     <= 1'b1;
               end else begin
                  beat        <= beat_t'(beat + 2'd1);
                  sysdata_out <= (rw == RW_READ) ? rd_byte : 8'h00;
               end
            end
            DONE: begin
               state   <= IDLE;
               sysbusy <= 1'b0;
               sysdone <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_mem_responder.sv
// Purpose : directed bench for sys_mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
// Latency : checks every cycle of each transfer against the cycle map of the request.
// Backpres: n/a; stimulus drives one request at a time and waits its full length.
module tb_sys_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        stb;
   logic        sel;        // 0: WAIT_STATES=2 instance, 1: WAIT_STATES=0 instance
   logic        sysrw;
   logic [15:0] sysaddress;
   logic [7:0]  sysdata_in;

   logic        stb2, stb0;
   logic [7:0]  dat2, dat0;
   logic        vld2, busy2, done2;
   logic        vld0, busy0, done0;

   assign stb2 = stb & ~sel;
   assign stb0 = stb & sel;

   sys_mem_responder #(.ADDR_W(16), .WAIT_STATES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sysstrobe   (stb2),
      .sysrw       (sysrw),
      .sysaddress  (sysaddress),
      .sysdata_in  (sysdata_in),
      .sysdata_out (dat2),
      .sysvalid    (vld2),
      .sysbusy     (busy2),
      .sysdone     (done2)
   );

   sys_mem_responder #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .sysstrobe   (stb0),
      .sysrw       (sysrw),
      .sysaddress  (sysaddress),
      .sysdata_in  (sysdata_in),
      .sysdata_out (dat0),
      .sysvalid    (vld0),
      .sysbusy     (busy0),
      .sysdone     (done0)
   );

   logic [7:0] o_dat;
   logic       o_vld, o_busy, o_done;
   assign o_dat  = sel ? dat0  : dat2;
   assign o_vld  = sel ? vld0  : vld2;
   assign o_busy = sel ? busy0 : busy2;
   assign o_done = sel ? done0 : done2;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full request on the selected instance. wd/rd pack byte k in bits [8k+7:8k].
   // Returns one cycle after the IDLE cycle that follows DONE.
   task automatic xfer(input string name, input logic rw, input logic [15:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd);
      int w;
      int k;
      w  = sel ? 0 : 2;
      rd = '0;
      sysrw      = rw;
      sysaddress = addr;
      stb        = 1'b1;
      @(posedge clk); #1;
      stb        = 1'b0;
      sysrw      = ~rw;
      sysaddress = ~addr;
      for (int c = 1; c <= 6 + w; c++) begin
         k = c - 1 - w;
         sysdata_in = 8'hEE;
         if (rw == 1'b0 && k >= 0 && k < 4) sysdata_in = wd[8*k +: 8];
         @(negedge clk);
         chk($sformatf("%s busy c%0d", name, c),  32'(o_busy), 32'(c <= 5 + w));
         chk($sformatf("%s valid c%0d", name, c), 32'(o_vld),  32'(k >= 0 && k < 4));
         chk($sformatf("%s done c%0d", name, c),  32'(o_done), 32'(c == 5 + w));
         if (rw == 1'b1 && k >= 0 && k < 4) rd[8*k +: 8] = o_dat;
         else chk($sformatf("%s data0 c%0d", name, c), 32'(o_dat), 32'h0);
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] rd;
   logic [31:0] dummy;
   int          ndone, nvld;

   initial begin
      rst_n      = 1'b0;
      stb        = 1'b0;
      sel        = 1'b0;
      sysrw      = 1'b1;
      sysaddress = '0;
      sysdata_in = '0;

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset data2",  32'(dat2),  32'h0);
      chk("reset valid2", 32'(vld2),  32'h0);
      chk("reset busy2",  32'(busy2), 32'h0);
      chk("reset done2",  32'(done2), 32'h0);
      chk("reset data0",  32'(dat0),  32'h0);
      chk("reset busy0",  32'(busy0), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Preload 0x0040..0x0043 and read it back with full timing checks.
      xfer("pre40", 1'b0, 16'h0040, 32'h44332211, dummy);
      xfer("rd40", 1'b1, 16'h0040, 32'h0, rd);
      chk("rd40 bytes", rd, 32'h44332211);

      // Write 0x1230 between two known neighbour words.
      xfer("pre122c", 1'b0, 16'h122C, 32'h08070605, dummy);
      xfer("pre1234", 1'b0, 16'h1234, 32'h0C0B0A09, dummy);
      xfer("wr1230", 1'b0, 16'h1230, 32'hD4C3B2A1, dummy);
      xfer("rd1230", 1'b1, 16'h1230, 32'h0, rd);
      chk("rd1230 bytes", rd, 32'hD4C3B2A1);
      xfer("rd122c", 1'b1, 16'h122C, 32'h0, rd);
      chk("0x122F unchanged", 32'(rd[31:24]), 32'h08);
      xfer("rd1234", 1'b1, 16'h1234, 32'h0, rd);
      chk("0x1234 unchanged", 32'(rd[7:0]), 32'h09);

      // Unaligned read request.
      xfer("rd43", 1'b1, 16'h0043, 32'h0, rd);
`ifdef SYS_MEM_CRIT_WORD_EN
      chk("rd43 crit order", rd, 32'h33221144);
`else
      chk("rd43 aligned", rd, 32'h44332211);
`endif

      // Stray strobes in WAIT (c1), beat 2 (c5) and DONE (c7) must be dropped.
      sysrw      = 1'b1;
      sysaddress = 16'h0040;
      stb        = 1'b1;
      @(posedge clk); #1;
      ndone = 0;
      nvld  = 0;
      for (int c = 1; c <= 10; c++) begin
         stb        = (c == 1 || c == 5 || c == 7);
         sysrw      = 1'b0;
         sysaddress = 16'h1230;
         sysdata_in = 8'h5E;
         @(negedge clk);
         ndone += int'(done2);
         nvld  += int'(vld2);
         @(posedge clk); #1;
      end
      stb = 1'b0;
      chk("stray done count", 32'(ndone), 32'd1);
      chk("stray valid count", 32'(nvld), 32'd4);
      xfer("after stray", 1'b1, 16'h1230, 32'h0, rd);
      chk("after stray bytes", rd, 32'hD4C3B2A1);

      // Reset during write beat 1 at 0x0800.
      xfer("pre800", 1'b0, 16'h0800, 32'h04030201, dummy);
      sysrw      = 1'b0;
      sysaddress = 16'h0800;
      stb        = 1'b1;
      @(posedge clk); #1;                   // cycle 1
      stb        = 1'b0;
      sysdata_in = 8'h5A;
      @(posedge clk); #1;                   // cycle 2
      @(posedge clk); #1;                   // cycle 3: beat 0
      @(negedge clk);
      chk("abort beat0 valid", 32'(vld2), 32'h1);
      @(posedge clk); #1;                   // cycle 4: beat 1
      sysdata_in = 8'h6B;
      rst_n      = 1'b0;
      @(posedge clk); #1;                   // cycle 5: reset taken
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort valid", 32'(vld2),  32'h0);
      chk("abort busy",  32'(busy2), 32'h0);
      chk("abort done",  32'(done2), 32'h0);
      chk("abort data",  32'(dat2),  32'h0);
      @(posedge clk); #1;
      xfer("rd800", 1'b1, 16'h0800, 32'h0, rd);
      chk("abort bytes", rd, 32'h0403025A);

      // Zero wait states, top-of-memory word.
      sel = 1'b1;
      xfer("w0 wr0000", 1'b0, 16'h0000, 32'h99989796, dummy);
      xfer("w0 wrfffc", 1'b0, 16'hFFFC, 32'hE4E3E2E1, dummy);
      xfer("w0 rdfffc", 1'b1, 16'hFFFC, 32'h0, rd);
      chk("w0 fffc bytes", rd, 32'hE4E3E2E1);
      xfer("w0 rd0000", 1'b1, 16'h0000, 32'h0, rd);
      chk("w0 0000 untouched", rd, 32'h99989796);
      sel = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
